maze_query_arbiter: RTL and testbench

- Shares one synchronous maze-map ROM read port among NUM_REQ moving sprites (requester 0 = pacman, 1..N-1 = ghosts).
- Each request is a single "can I move one pixel in direction d?" query. The block converts the query into a tile address, reads the ROM and returns a one-cycle ack with the collide bit.
- Replaces the per-sprite, per-direction collision lookups with one round-robin scheduled resource.

---
 rtl/maze_query_arbiter_if.sv | 36 +++
 rtl/maze_query_arbiter.sv | 169 ++++++++++++++++
 tb/tb_maze_query_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/maze_query_arbiter_if.sv
// maze_query_arbiter_if
// Bundles the sprite query bus and the maze ROM read port of the
// maze_query_arbiter.
//   req/req_x/req_y/req_dir : per-requester query (9-bit x/y, one-hot dir)
//   ack/collide             : one-cycle response pulse and wall result
//   busy/grant_id           : arbiter status
//   rom_en/rom_addr         : ROM read strobe and tile address
//   rom_data                : ROM wall bit returned ROM_LATENCY cycles later
// slave  : the arbiter side.
// master : the environment (sprites plus ROM).
interface maze_query_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*9-1:0] req_x;
    logic [NUM_REQ*9-1:0] req_y;
    logic [NUM_REQ*4-1:0] req_dir;
    logic [NUM_REQ-1:0]   ack;
    logic                 collide;
    logic                 busy;
    logic [2:0]           grant_id;
    logic                 rom_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic                 rom_data;

    modport slave (
        input  req, req_x, req_y, req_dir, rom_data,
        output ack, collide, busy, grant_id, rom_en, rom_addr
    );

    modport master (
        output req, req_x, req_y, req_dir, rom_data,
        input  ack, collide, busy, grant_id, rom_en, rom_addr
    );
endinterface

// File: rtl/maze_query_arbiter.sv
// maze_query_arbiter
// Shares one synchronous maze ROM read port among NUM_REQ sprites. Each query
// asks whether a sprite may move one pixel in a direction; the arbiter picks a
// requester round-robin, turns the probe pixel into a tile address, reads the
// ROM and returns a one-cycle ack with the collide bit.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : maze_query_arbiter_if.slave (query bus + ROM port)
// Optional build macro MAZE_ARB_PACMAN_PRIO_EN: requester 0 (pacman) wins
// every grant it asks for; the others share round-robin among themselves.
module maze_query_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 1,
    parameter int TILE        = 12,
    parameter int SPRITE_W    = 12,
    parameter int MAP_COLS    = 28,
    parameter int MAP_ROWS    = 31,
    parameter int ADDR_W      = 10
) (
    input logic clk,
    input logic rst,
    maze_query_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] rr_ptr, rr_nxt, gnt_idx, grant_r;
    logic       gnt_vld;
    logic [8:0] x_r, y_r, sel_x, sel_y;
    logic [3:0] dir_r, sel_dir;
    logic [1:0] wait_cnt;
    logic       forced_r, collide_r;

    logic [9:0]  px, py, col, row;
    logic [19:0] addr_full;
    logic        oob;

    // Round-robin pick: lowest set index at or above rr_ptr, else lowest set
    // index overall (the wrap). Loop indices are constants, so no variable
    // bit selects are needed.
    always_comb begin
        logic       hi_vld, lo_vld;
        logic [2:0] hi_idx, lo_idx;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_vld = 1'b1;
                lo_idx = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = 3'(i);
                end
            end
        end
        gnt_vld = lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
`ifdef MAZE_ARB_PACMAN_PRIO_EN
        if (bus.req[0]) gnt_idx = 3'd0;
`endif
        rr_nxt = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_dir = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 3'(i)) begin
                sel_x   = bus.req_x[9*i +: 9];
                sel_y   = bus.req_y[9*i +: 9];
                sel_dir = bus.req_dir[4*i +: 4];
            end
        end
    end

    // Probe pixel and tile address from the latched query. 10-bit math keeps
    // x+SPRITE_W from wrapping; the x-1 / y-1 wrap at zero is masked by oob.
    always_comb begin
        px = {1'b0, x_r};
        py = {1'b0, y_r};
        case (dir_r)
            4'b1000: px = px - 10'd1;
            4'b0100: py = py - 10'd1;
            4'b0010: px = px + 10'(SPRITE_W);
            4'b0001: py = py + 10'(SPRITE_W);
            default: ;
        endcase
        col       = px / 10'(TILE);
        row       = py / 10'(TILE);
        addr_full = 20'(row) * 20'(MAP_COLS) + 20'(col);
        oob = (x_r == 9'd0 && dir_r == 4'b1000) ||
              (y_r == 9'd0 && dir_r == 4'b0100) ||
              (col >= 10'(MAP_COLS)) || (row >= 10'(MAP_ROWS)) ||
              !$onehot(dir_r);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (gnt_vld) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (wait_cnt == 2'(ROM_LATENCY - 1)) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs. rom_en is combinational in ISSUE so the ROM word lands on
    // the last WAIT cycle, giving ack at grant + 2 + ROM_LATENCY.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            bus.ack[i] = (state == RESP) && (grant_r == 3'(i));
        bus.collide  = (state == RESP) && collide_r;
        bus.busy     = (state != IDLE);
        bus.grant_id = grant_r;
        bus.rom_en   = (state == ISSUE) && !oob;
        bus.rom_addr = bus.rom_en ? addr_full[ADDR_W-1:0] : '0;
    end

    // Query datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_r   <= '0;
            x_r       <= '0;
            y_r       <= '0;
            dir_r     <= '0;
            wait_cnt  <= '0;
            forced_r  <= 1'b0;
            collide_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_vld) begin
                    grant_r <= gnt_idx;
                    x_r     <= sel_x;
                    y_r     <= sel_y;
                    dir_r   <= sel_dir;
`ifdef MAZE_ARB_PACMAN_PRIO_EN
                    // Pacman grants leave the ghosts' rotation untouched.
                    if (gnt_idx != 3'd0) rr_ptr <= rr_nxt;
`else
                    rr_ptr <= rr_nxt;
`endif
                end
                ISSUE: begin
                    forced_r <= oob;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == 2'(ROM_LATENCY - 1))
                        collide_r <= forced_r | bus.rom_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_query_arbiter.sv
// tb_maze_query_arbiter
// Directed bench for maze_query_arbiter with a one-wall ROM model (addr 548)
// and default parameters. Honors MAZE_ARB_PACMAN_PRIO_EN in its expectations.
module tb_maze_query_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    maze_query_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

    maze_query_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous ROM, latency 1: only address 548 holds a wall.
    always @(posedge clk) begin
        if (rst)             bus.rom_data <= 1'b0;
        else if (bus.rom_en) bus.rom_data <= (bus.rom_addr == 10'd548);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One query: drive mask with identical operands on all lanes, then scramble
    // the operands after grant to show they were latched.
    task automatic run_query(input string tag, input logic [3:0] mask, input int exp_idx,
                             input logic [8:0] x, input logic [8:0] y, input logic [3:0] dir,
                             input int exp_en, input int exp_addr, input logic exp_col);
        int n, en_cnt, addr_seen;
        logic got;
        @(negedge clk);
        bus.req     = mask;
        bus.req_x   = {NUM_REQ{x}};
        bus.req_y   = {NUM_REQ{y}};
        bus.req_dir = {NUM_REQ{dir}};
        n = 0; en_cnt = 0; addr_seen = 0; got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_busy"}, 32'(bus.busy), 1);
                chk({tag, "_gid"}, 32'(bus.grant_id), exp_idx);
                bus.req_x   = '1;
                bus.req_y   = '1;
                bus.req_dir = '1;
            end
            if (bus.rom_en) begin
                en_cnt++;
                addr_seen = int'(bus.rom_addr);
            end
            if (bus.ack != '0) begin
                got = 1'b1;
                chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << exp_idx);
                chk({tag, "_col"}, 32'(bus.collide), 32'(exp_col));
                chk({tag, "_busyack"}, 32'(bus.busy), 1);
            end
        end
        bus.req = '0;
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_en"}, en_cnt, exp_en);
        if (exp_en != 0) chk({tag, "_addr"}, addr_seen, exp_addr);
        @(negedge clk);
        chk({tag, "_idle"}, 32'({bus.busy, bus.ack}), 0);
    endtask

    initial begin
        int acks[5];
        int cyc[5];
        int na, n, idx;
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_x   = '0;
        bus.req_y   = '0;
        bus.req_dir = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_col", 32'(bus.collide), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        chk("rst_en", 32'(bus.rom_en), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        rst = 1'b0;

        // Wall hits and a free tile.
        run_query("q_r548", 4'b0001, 0, 9'd180, 9'd228, 4'b0010, 1, 548, 1'b1);
        run_query("q_l548", 4'b0001, 0, 9'd200, 9'd230, 4'b1000, 1, 548, 1'b1);
        run_query("q_u57",  4'b0001, 0, 9'd12,  9'd36,  4'b0100, 1, 57,  1'b0);
        // Forced collisions: no ROM read, same latency.
        run_query("f_x0l",   4'b0010, 1, 9'd0,   9'd100, 4'b1000, 0, 0, 1'b1);
        run_query("f_dir",   4'b0010, 1, 9'd100, 9'd100, 4'b0110, 0, 0, 1'b1);
        run_query("f_col29", 4'b0010, 1, 9'd340, 9'd100, 4'b0010, 0, 0, 1'b1);

        // Four sprites requesting continuously from rr_ptr=0.
        do_reset();
        @(negedge clk);
        bus.req_x   = {NUM_REQ{9'd180}};
        bus.req_y   = {NUM_REQ{9'd228}};
        bus.req_dir = {NUM_REQ{4'b0010}};
        bus.req     = 4'b1111;
        na = 0; n = 0;
        while (na < 5 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ack != '0) begin
                idx = 0;
                for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) idx = i;
                acks[na] = idx;
                cyc[na]  = n;
                na++;
            end
        end
        bus.req = '0;
        chk("rr_count", na, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < na) begin
`ifdef MAZE_ARB_PACMAN_PRIO_EN
                chk($sformatf("rr_id%0d", k), acks[k], 0);
`else
                chk($sformatf("rr_id%0d", k), acks[k], k % NUM_REQ);
`endif
                chk($sformatf("rr_cyc%0d", k), cyc[k], 3 + 4 * k);
            end
        end
        n = 0;
        while (bus.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rr_drain", 32'(bus.busy), 0);

        // Reset in the middle of a query.
        do_reset();
        @(negedge clk);
        bus.req_x   = {NUM_REQ{9'd180}};
        bus.req_y   = {NUM_REQ{9'd228}};
        bus.req_dir = {NUM_REQ{4'b0010}};
        bus.req     = 4'b0100;
        @(negedge clk);
        chk("mid_gid", 32'(bus.grant_id), 2);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("mid_ack", 32'(bus.ack), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_en", 32'(bus.rom_en), 0);
        chk("mid_gid0", 32'(bus.grant_id), 0);
        rst = 1'b0;
        na = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack != '0) na++;
        end
        chk("mid_noack", na, 0);
        run_query("post_rst", 4'b0110, 1, 9'd180, 9'd228, 4'b0010, 1, 548, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
